syscall_issue: RTL and testbench

Processor-side initiator for operating-system calls. It sits between the decode stage and the system-call handler. When a syscall (instruction ID 26) is decoded, it captures the call code and argument and stalls the pipeline. It then drives a req/ack handshake toward the handler, writes back any returned value for read calls, and latches a halted state on exit.

---
 rtl/syscall_issue_if.sv | 18 +
 rtl/syscall_issue.sv | 177 +++++++++++++++++
 tb/tb_syscall_issue.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/syscall_issue_if.sv
// Handshake bus between the syscall initiator (master) and the system-call handler (slave).
interface syscall_issue_if;
    logic        sys_req;
    logic [31:0] sys_code;
    logic [31:0] sys_arg;
    logic        sys_ack;
    logic [31:0] sys_data;

    modport master (
        output sys_req, sys_code, sys_arg,
        input  sys_ack, sys_data
    );

    modport slave (
        input  sys_req, sys_code, sys_arg,
        output sys_ack, sys_data
    );
endinterface

// File: rtl/syscall_issue.sv
// Syscall initiator: captures a decoded syscall, stalls the pipe, runs the req/ack handshake.
// Optional REQ timeout is enabled by defining SYSCALL_TIMEOUT_EN.
module syscall_issue #(
    parameter logic [31:0] ID_SYSCALL = 32'd26
`ifdef SYSCALL_TIMEOUT_EN
   ,parameter int          TIMEOUT    = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [31:0]            instr_ID,
    input  logic [31:0]            rs,
    input  logic [31:0]            rt,
    input  logic [4:0]             rd_idx,
    output logic                   stall,
    syscall_issue_if.master        sys_if,
    output logic                   wb_en,
    output logic [4:0]             wb_idx,
    output logic [31:0]            wb_data,
    output logic                   halted,
    output logic                   err
);

    localparam logic [31:0] CODE_DISPLAY = 32'd1;
    localparam logic [31:0] CODE_READ    = 32'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic        sys_req_q, sys_req_d;
    logic [31:0] code_q, code_d;
    logic [31:0] arg_q, arg_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_en_q, wb_en_d;
    logic        halted_q, halted_d;
    logic        accept;
    logic        is_display, is_read;

`ifdef SYSCALL_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign accept     = valid_in && (instr_ID == ID_SYSCALL);
    assign is_display = (code_q == CODE_DISPLAY);
    assign is_read    = (code_q == CODE_READ);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        sys_req_d = sys_req_q;
        code_d    = code_q;
        arg_d     = arg_q;
        idx_d     = idx_q;
        wb_data_d = wb_data_q;
        wb_en_d   = 1'b0;
        halted_d  = halted_q;
`ifdef SYSCALL_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    code_d    = rs;
                    arg_d     = rt;
                    idx_d     = rd_idx;
                    sys_req_d = 1'b1;
                    state_d   = S_REQ;
`ifdef SYSCALL_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end

            S_REQ: begin
                // An ack on the expiry cycle takes priority over the timeout.
                if (sys_if.sys_ack) begin
                    sys_req_d = 1'b0;
                    if (is_read) begin
                        wb_data_d = sys_if.sys_data;
                        wb_en_d   = (idx_q != 5'd0);
                        state_d   = S_WB;
                    end else if (is_display) begin
                        state_d   = S_IDLE;
                    end else begin
                        halted_d  = 1'b1;
                        state_d   = S_HALT;
                    end
                end
`ifdef SYSCALL_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    sys_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (is_read || is_display) begin
                        state_d  = S_IDLE;
                    end else begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            S_WB: begin
                state_d = S_IDLE;
            end

            default: begin
                // HALT is absorbing; only reset leaves it.
                state_d = S_HALT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sys_req_q <= 1'b0;
            code_q    <= '0;
            arg_q     <= '0;
            idx_q     <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sys_req_q <= sys_req_d;
            code_q    <= code_d;
            arg_q     <= arg_d;
            idx_q     <= idx_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            halted_q  <= halted_d;
        end
    end

`ifdef SYSCALL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign stall           = accept || (state_q != S_IDLE);
    assign sys_if.sys_req  = sys_req_q;
    assign sys_if.sys_code = code_q;
    assign sys_if.sys_arg  = arg_q;
    assign wb_en           = wb_en_q;
    assign wb_idx          = idx_q;
    assign wb_data         = wb_data_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_syscall_issue.sv
// Bench for syscall_issue: directed scenarios plus random traffic against a transaction-level model.
module tb_syscall_issue;

    localparam logic [31:0] ID_SC = 32'd26;
`ifdef SYSCALL_TIMEOUT_EN
    localparam int TO = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] instr_id;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd_idx;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        halted;
    logic        err;

    syscall_issue_if bus ();

`ifdef SYSCALL_TIMEOUT_EN
    syscall_issue #(.ID_SYSCALL(ID_SC), .TIMEOUT(TO)) dut (
`else
    syscall_issue #(.ID_SYSCALL(ID_SC)) dut (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .instr_ID (instr_id),
        .rs       (rs),
        .rt       (rt),
        .rd_idx   (rd_idx),
        .stall    (stall),
        .sys_if   (bus),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx),
        .wb_data  (wb_data),
        .halted   (halted),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_err;

    // Reference model: what the handler interaction should look like, tracked per call.
    bit          m_known;
    bit          m_req;
    bit          m_wb;
    bit          m_halted;
    bit          m_err;
    int          m_age;
    logic [31:0] m_code;
    logic [31:0] m_arg;
    logic [31:0] m_data;
    logic [4:0]  m_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic cycle(input bit r, input bit v, input logic [31:0] id, input logic [31:0] c,
                         input logic [31:0] a, input logic [4:0] idx, input bit ack,
                         input logic [31:0] data);
        bit acc;
        rst_n        = r;
        valid_in     = v;
        instr_id     = id;
        rs           = c;
        rt           = a;
        rd_idx       = idx;
        bus.sys_ack  = ack;
        bus.sys_data = data;
        #1;
        acc = v && (id == ID_SC);
        if (m_known) begin
            check("sys_req",  {31'b0, bus.sys_req}, {31'b0, m_req});
            check("sys_code", bus.sys_code, m_code);
            check("sys_arg",  bus.sys_arg, m_arg);
            check("wb_en",    {31'b0, wb_en}, {31'b0, (m_wb && m_idx != 5'd0)});
            check("wb_idx",   {27'b0, wb_idx}, {27'b0, m_idx});
            check("wb_data",  wb_data, m_data);
            check("halted",   {31'b0, halted}, {31'b0, m_halted});
            check("err",      {31'b0, err}, {31'b0, m_err});
            check("stall",    {31'b0, stall}, {31'b0, (m_req || m_wb || m_halted || acc)});
        end

        if (!r) begin
            m_known  = 1'b1;
            m_req    = 1'b0;
            m_wb     = 1'b0;
            m_halted = 1'b0;
            m_err    = 1'b0;
            m_age    = 0;
            m_code   = '0;
            m_arg    = '0;
            m_data   = '0;
            m_idx    = '0;
        end else if (m_known) begin
            m_err = 1'b0;
            if (m_halted) begin
                m_age = 0;
            end else if (m_wb) begin
                m_wb = 1'b0;
            end else if (m_req) begin
                if (ack) begin
                    m_req = 1'b0;
                    if (m_code == 32'd2) begin
                        m_data = data;
                        m_wb   = 1'b1;
                    end else if (m_code != 32'd1) begin
                        m_halted = 1'b1;
                    end
                end
`ifdef SYSCALL_TIMEOUT_EN
                else if (m_age == TO) begin
                    m_req = 1'b0;
                    m_err = 1'b1;
                    if (m_code != 32'd1 && m_code != 32'd2) m_halted = 1'b1;
                end
`endif
                else begin
                    m_age++;
                end
            end else if (acc) begin
                m_req  = 1'b1;
                m_age  = 1;
                m_code = c;
                m_arg  = a;
                m_idx  = idx;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic ack_only(input logic [31:0] data);
        cycle(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, data);
    endtask

    task automatic call(input logic [31:0] c, input logic [31:0] a, input logic [4:0] idx);
        cycle(1'b1, 1'b1, ID_SC, c, a, idx, 1'b0, 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        m_known      = 1'b0;
        rst_n        = 1'b0;
        valid_in     = 1'b0;
        instr_id     = '0;
        rs           = '0;
        rt           = '0;
        rd_idx       = '0;
        bus.sys_ack  = 1'b0;
        bus.sys_data = '0;
        @(negedge clk);

        // Reset, then non-syscall and spurious-ack noise in IDLE.
        repeat (2) cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        repeat (3) cycle(1'b1, 1'b1, 32'd7, 32'd1, 32'h55, 5'd3, 1'b1, 32'hFFFF_FFFF);
        ack_only(32'h0BAD_0BAD);

        // Display, ack three cycles after acceptance.
        call(32'd1, 32'h1234, 5'd3);
        idle();
        idle();
        ack_only(32'hAAAA_AAAA);
        idle();

        // Read into r5, then read into r0.
        call(32'd2, 32'h7, 5'd5);
        ack_only(32'hDEAD_BEEF);
        idle();
        idle();
        call(32'd2, 32'h8, 5'd0);
        ack_only(32'h1111_2222);
        idle();
        idle();

        // Back-to-back: new call presented on the cycle the FSM returns to IDLE.
        call(32'd1, 32'h42, 5'd1);
        ack_only(32'd0);
        call(32'd2, 32'h43, 5'd9);
        ack_only(32'hCAFE_F00D);
        call(32'd1, 32'h44, 5'd2);
        ack_only(32'd0);
        idle();

        // Exit, then later syscalls and acks are ignored until reset.
        call(32'd0, 32'h99, 5'd4);
        idle();
        ack_only(32'd5);
        repeat (3) cycle(1'b1, 1'b1, ID_SC, 32'd2, 32'h77, 5'd6, 1'b1, 32'h1234_5678);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        idle();
        idle();

`ifdef SYSCALL_TIMEOUT_EN
        // Timeout with no ack, then ack landing exactly on the expiry cycle.
        call(32'd1, 32'h5, 5'd1);
        repeat (6) idle();
        call(32'd1, 32'h6, 5'd1);
        repeat (TO - 1) idle();
        ack_only(32'd0);
        idle();
        call(32'd2, 32'h7, 5'd7);
        repeat (6) idle();
        call(32'd3, 32'h8, 5'd7);
        repeat (6) idle();
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        idle();
`endif

        // Random traffic, including mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          v;
            bit          ak;
            int          sel;
            logic [31:0] id;
            logic [31:0] c;
            r   = ($urandom_range(0, 99) >= (m_halted ? 20 : 2));
            v   = ($urandom_range(0, 9) < 7);
            id  = ($urandom_range(0, 1) == 1) ? ID_SC : 32'($urandom_range(0, 40));
            sel = $urandom_range(0, 9);
            c   = (sel < 4) ? 32'd1 : (sel < 8) ? 32'd2 : (sel == 8) ? 32'd0 : 32'($urandom);
            ak  = ($urandom_range(0, 99) < 35);
            cycle(r, v, id, c, 32'($urandom), 5'($urandom_range(0, 31)), ak, 32'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
